// File: rtl/fetch_pkg.sv
// Shared types and control-code constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_L  = 3'd1,
    ST_FETCH_H  = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  localparam logic [1:0] ARF_FUN_INC        = 2'b01;
  localparam logic [1:0] IR_FUN_LOAD        = 2'b10;
  localparam logic [1:0] ARF_SEL_PC         = 2'b00;
  localparam logic [3:0] ARF_REGSEL_PC_ONLY = 4'b0111;
  localparam logic [3:0] ARF_REGSEL_NONE    = 4'b1111;
  localparam logic       MEM_CS_ON          = 1'b0;
  localparam logic       MEM_CS_OFF         = 1'b1;
  localparam logic       MEM_READ           = 1'b0;

  typedef struct packed {
    logic [1:0] arf_outd_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
  } ctrl_word_t;

  // Quiescent word: memory deselected, no register enabled.
  localparam ctrl_word_t CTRL_IDLE = '{
    arf_outd_sel: 2'b00,
    arf_fun_sel:  2'b00,
    arf_reg_sel:  ARF_REGSEL_NONE,
    ir_lh:        1'b0,
    ir_enable:    1'b0,
    ir_funsel:    2'b00,
    mem_wr:       MEM_READ,
    mem_cs:       MEM_CS_OFF
  };

endpackage

// File: rtl/fetch_ctrl_decode.sv
// Combinational state -> ALU_System fetch-phase control word decoder.
module fetch_ctrl_decode
  import fetch_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    if (state == ST_FETCH_L || state == ST_FETCH_H) begin
      ctrl.mem_cs       = MEM_CS_ON;
      ctrl.mem_wr       = MEM_READ;
      ctrl.arf_outd_sel = ARF_SEL_PC;
      ctrl.arf_fun_sel  = ARF_FUN_INC;
      ctrl.arf_reg_sel  = ARF_REGSEL_PC_ONLY;
      ctrl.ir_enable    = 1'b1;
      ctrl.ir_funsel    = IR_FUN_LOAD;
      ctrl.ir_lh        = (state == ST_FETCH_H);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: two-byte IR fetch, valid/ready hand-off, timing counter.
// Optional FETCH_PERF_EN adds the stall_cycles performance counter.
//
// state       | meaning
// ST_IDLE     | after reset, waiting for start
// ST_FETCH_L  | reading low byte at PC into IR[7:0], PC++
// ST_FETCH_H  | reading high byte at PC into IR[15:8], PC++
// ST_DISPATCH | instr valid, waiting for instr_ready
// ST_HALT     | stopped by halt_req, waiting for start
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int T_WIDTH     = 3,
  parameter int COUNT_WIDTH = 8
)
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic [15:0]            ir_in,
  output logic                   instr_valid,
  output logic [15:0]            instr,
  input  logic                   instr_ready,
  output logic [1:0]             ARF_OutDSel,
  output logic [1:0]             ARF_FunSel,
  output logic [3:0]             ARF_RegSel,
  output logic                   IR_LH,
  output logic                   IR_Enable,
  output logic [1:0]             IR_Funsel,
  output logic                   Mem_WR,
  output logic                   Mem_CS,
  output logic [T_WIDTH-1:0]     seq_t,
  output logic [COUNT_WIDTH-1:0] fetch_count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  localparam logic [T_WIDTH-1:0] T_MAX      = '1;
  localparam logic [T_WIDTH-1:0] T_FETCH_H  = T_WIDTH'(1);
  localparam logic [T_WIDTH-1:0] T_DISPATCH = T_WIDTH'(2);

  state_t     state;
  ctrl_word_t ctrl;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      instr_valid <= 1'b0;
      instr       <= 16'h0000;
      seq_t       <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          seq_t <= '0;
          if (start) state <= ST_FETCH_L;
        end
        ST_FETCH_L: begin
          state <= ST_FETCH_H;
          seq_t <= T_FETCH_H;
        end
        // ir_in already carries the high byte being loaded on this edge.
        ST_FETCH_H: begin
          state       <= ST_DISPATCH;
          instr       <= ir_in;
          instr_valid <= 1'b1;
          seq_t       <= T_DISPATCH;
        end
        ST_DISPATCH: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + COUNT_WIDTH'(1);
            seq_t       <= '0;
            state       <= halt_req ? ST_HALT : ST_FETCH_L;
          end else if (seq_t != T_MAX) begin
            seq_t <= seq_t + T_WIDTH'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          instr_valid <= 1'b0;
          seq_t       <= '0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge Clock) begin
    if (Reset)
      stall_cycles <= 16'h0000;
    else if (state == ST_DISPATCH && !instr_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

  fetch_ctrl_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign ARF_OutDSel = ctrl.arf_outd_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Enable   = ctrl.ir_enable;
  assign IR_Funsel   = ctrl.ir_funsel;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small memory/PC/IR model of ALU_System.
module tb_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, start, halt_req, instr_ready;
  logic [15:0] ir_in, instr;
  logic        instr_valid;
  logic [1:0]  ARF_OutDSel, ARF_FunSel, IR_Funsel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable, Mem_WR, Mem_CS;
  logic [2:0]  seq_t;
  logic [7:0]  fetch_count;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  // {OutDSel, FunSel, RegSel, LH, IR_En, IR_Fun, WR, CS}
  localparam logic [13:0] CTRL_IDLE_E = 14'b00_00_1111_0_0_00_0_1;
  localparam logic [13:0] CTRL_FL_E   = 14'b00_01_0111_0_1_10_0_0;
  localparam logic [13:0] CTRL_FH_E   = 14'b00_01_0111_1_1_10_0_0;
  logic [13:0] ctrl_obs;
  assign ctrl_obs = {ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS};

  fetch_sequencer dut (
    .Clock(Clock), .Reset(Reset), .start(start), .halt_req(halt_req), .ir_in(ir_in),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .seq_t(seq_t), .fetch_count(fetch_count)
`ifdef FETCH_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 Clock = ~Clock;

  // ALU_System model: byte memory, PC (not reset by the sequencer), IR with flow-through output.
  logic [7:0]  mem [0:1023];
  logic [15:0] pc = 16'h0000;
  logic [15:0] ir_q = 16'h0000;

  always @(posedge Clock) begin
    if (IR_Enable && IR_Funsel == 2'b10 && !Mem_CS && !Mem_WR && ARF_OutDSel == 2'b00) begin
      if (IR_LH) ir_q[15:8] <= mem[pc[9:0]];
      else       ir_q[7:0]  <= mem[pc[9:0]];
    end
    if (ARF_RegSel == 4'b0111 && ARF_FunSel == 2'b01) pc <= pc + 16'd1;
  end

  always_comb begin
    ir_in = ir_q;
    if (IR_Enable) ir_in = IR_LH ? {mem[pc[9:0]], ir_q[7:0]} : {ir_q[15:8], mem[pc[9:0]]};
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++; if (ctrl_obs !== CTRL_IDLE_E) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_obs, CTRL_IDLE_E); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", instr); end
    checks++; if (seq_t !== 3'd0) begin failures++; $display("FAIL reset_seq_t got=%0d exp=0", seq_t); end
    checks++; if (fetch_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    Reset = 1'b0;
    instr_ready = 1'b1;
    tick();
    checks++; if (ctrl_obs !== CTRL_IDLE_E || instr_valid !== 1'b0) begin failures++; $display("FAIL idle_hold got=%b/%b exp=%b/0", ctrl_obs, instr_valid, CTRL_IDLE_E); end
  endtask

  task automatic test_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ctrl_obs !== CTRL_FL_E) begin failures++; $display("FAIL fl_ctrl got=%b exp=%b", ctrl_obs, CTRL_FL_E); end
    checks++; if (seq_t !== 3'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL fl_seq got=%0d/%b exp=0/0", seq_t, instr_valid); end
    tick();
    checks++; if (ctrl_obs !== CTRL_FH_E) begin failures++; $display("FAIL fh_ctrl got=%b exp=%b", ctrl_obs, CTRL_FH_E); end
    checks++; if (seq_t !== 3'd1) begin failures++; $display("FAIL fh_seq got=%0d exp=1", seq_t); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234) begin failures++; $display("FAIL disp_instr got=%b/%h exp=1/1234", instr_valid, instr); end
    checks++; if (seq_t !== 3'd2 || ctrl_obs !== CTRL_IDLE_E) begin failures++; $display("FAIL disp_out got=%0d/%b exp=2/%b", seq_t, ctrl_obs, CTRL_IDLE_E); end
    checks++; if (pc !== 16'd2) begin failures++; $display("FAIL disp_pc got=%0d exp=2", pc); end
    tick();
    checks++; if (ctrl_obs !== CTRL_FL_E || instr_valid !== 1'b0) begin failures++; $display("FAIL next_fl got=%b/%b exp=%b/0", ctrl_obs, instr_valid, CTRL_FL_E); end
    checks++; if (fetch_count !== 8'd1 || seq_t !== 3'd0) begin failures++; $display("FAIL next_count got=%0d/%0d exp=1/0", fetch_count, seq_t); end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (seq_t !== 3'(2 + k)) begin failures++; $display("FAIL stall_seq k=%0d got=%0d exp=%0d", k, seq_t, 2 + k); end
      checks++; if (instr_valid !== 1'b1 || instr !== 16'h5958) begin failures++; $display("FAIL stall_hold k=%0d got=%b/%h exp=1/5958", k, instr_valid, instr); end
      tick();
    end
    checks++; if (seq_t !== 3'd7) begin failures++; $display("FAIL stall_seq7 got=%0d exp=7", seq_t); end
    tick();
    checks++; if (seq_t !== 3'd7 || instr !== 16'h5958) begin failures++; $display("FAIL stall_sat got=%0d/%h exp=7/5958", seq_t, instr); end
    instr_ready = 1'b1;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (ctrl_obs !== CTRL_IDLE_E || instr_valid !== 1'b0) begin failures++; $display("FAIL halt_entry got=%b/%b exp=%b/0", ctrl_obs, instr_valid, CTRL_IDLE_E); end
    checks++; if (fetch_count !== 8'd2 || seq_t !== 3'd0) begin failures++; $display("FAIL halt_count got=%0d/%0d exp=2/0", fetch_count, seq_t); end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ctrl_obs !== CTRL_IDLE_E || seq_t !== 3'd0 || pc !== 16'd4) begin failures++; $display("FAIL halt_hold k=%0d got=%b/%0d/%0d exp=%b/0/4", k, ctrl_obs, seq_t, pc, CTRL_IDLE_E); end
    end
    halt_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ctrl_obs !== CTRL_FL_E || pc !== 16'd4) begin failures++; $display("FAIL resume got=%b/%0d exp=%b/4", ctrl_obs, pc, CTRL_FL_E); end
    tick();
    tick();
    checks++; if (instr !== 16'h5F5E || pc !== 16'd6) begin failures++; $display("FAIL resume_instr got=%h/%0d exp=5f5e/6", instr, pc); end
    tick();
    checks++; if (fetch_count !== 8'd3 || ctrl_obs !== CTRL_FL_E) begin failures++; $display("FAIL resume_count got=%0d/%b exp=3/%b", fetch_count, ctrl_obs, CTRL_FL_E); end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    checks++; if (ctrl_obs !== CTRL_FH_E) begin failures++; $display("FAIL mid_fh got=%b exp=%b", ctrl_obs, CTRL_FH_E); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (ctrl_obs !== CTRL_IDLE_E || ARF_RegSel !== 4'b1111) begin failures++; $display("FAIL mid_ctrl got=%b exp=%b", ctrl_obs, CTRL_IDLE_E); end
    checks++; if (instr_valid !== 1'b0 || seq_t !== 3'd0 || fetch_count !== 8'd0 || instr !== 16'h0000) begin failures++; $display("FAIL mid_state got=%b/%0d/%0d/%h exp=0/0/0/0000", instr_valid, seq_t, fetch_count, instr); end
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    instr_ready = 1'b0;
    tick();
    checks++; if (ctrl_obs !== CTRL_FL_E || pc !== 16'd8) begin failures++; $display("FAIL si_fl got=%b/%0d exp=%b/8", ctrl_obs, pc, CTRL_FL_E); end
    tick();
    checks++; if (ctrl_obs !== CTRL_FH_E) begin failures++; $display("FAIL si_fh got=%b exp=%b", ctrl_obs, CTRL_FH_E); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h5352) begin failures++; $display("FAIL si_disp got=%b/%h exp=1/5352", instr_valid, instr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || seq_t !== 3'd3 || ctrl_obs !== CTRL_IDLE_E) begin failures++; $display("FAIL si_hold got=%b/%0d/%b exp=1/3/%b", instr_valid, seq_t, ctrl_obs, CTRL_IDLE_E); end
    start = 1'b0;
    instr_ready = 1'b1;
    tick();
    checks++; if (fetch_count !== 8'd1 || ctrl_obs !== CTRL_FL_E) begin failures++; $display("FAIL si_xfer got=%0d/%b exp=1/%b", fetch_count, ctrl_obs, CTRL_FL_E); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pc0;
    logic [15:0] exp_instr;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (fetch_count !== 8'd0) begin failures++; $display("FAIL b2b_reset got=%0d exp=0", fetch_count); end
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    pc0 = pc;
    for (int n = 1; n <= 256; n++) begin
      tick();
      tick();
      exp_instr = {mem[10'(pc - 16'd1)], mem[10'(pc - 16'd2)]};
      checks++; if (instr_valid !== 1'b1 || instr !== exp_instr) begin failures++; $display("FAIL b2b_instr n=%0d got=%b/%h exp=1/%h", n, instr_valid, instr, exp_instr); end
      tick();
      checks++; if (fetch_count !== 8'(n) || ctrl_obs !== CTRL_FL_E) begin failures++; $display("FAIL b2b_count n=%0d got=%0d/%b exp=%0d/%b", n, fetch_count, ctrl_obs, n % 256, CTRL_FL_E); end
    end
    checks++; if (pc !== pc0 + 16'd512) begin failures++; $display("FAIL b2b_pc got=%0d exp=%0d", pc, pc0 + 16'd512); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL perf_reset got=%0d exp=0", stall_cycles); end
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      instr_ready = 1'b0;
      tick();
      tick();
      tick();
      instr_ready = 1'b1;
      tick();
    end
    checks++; if (stall_cycles !== 16'd12) begin failures++; $display("FAIL perf_stalls got=%0d exp=12", stall_cycles); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h34;
    mem[1] = 8'h12;
    Reset = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    instr_ready = 1'b0;
    test_reset();
    test_fetch();
    test_stall();
    test_halt();
    test_reset_mid_fetch();
    test_start_ignored();
    test_back_to_back();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
